// File: rtl/reg_share_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding, lock cap, defaults.
// The optional hold-grant feature is enabled by defining ARB_LOCK_EN.
package reg_share_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 8;
  localparam int MAX_REQ   = 8;
  localparam int LOCK_MAX  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot vector (zero when the vector is empty).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational round-robin picker: search starts one past ptr and wraps,
// first set request wins; winner is one-hot, any_req flags a non-empty request vector.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             any_req_o
);

  logic [PW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    pos      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(ptr_i) + k) % N_REQ;
      idx = PW'(pos);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter granting N_REQ writers access to one shared DW-bit register.
// Optional ARB_LOCK_EN macro adds a lock port that holds the grant for up to LOCK_MAX writes.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*DW-1:0] wr_data,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]   lock,
`endif
  output logic [N_REQ-1:0]   gnt,
  output logic [DW-1:0]      q,
  output logic               q_vld,
  output logic               busy
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LCW = $clog2(LOCK_MAX);

  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [DW-1:0]    q_q;
  logic             q_vld_q;
  logic [PW-1:0]    ptr_q;
  logic [LCW-1:0]   lock_cnt_q;

  logic [N_REQ-1:0] win_d;
  logic             any_req_d;
  logic [DW-1:0]    wr_dat_d;
  logic [PW-1:0]    win_idx_d;
  logic             wr_ok_d;
  logic             hold_d;
  logic [N_REQ-1:0] lock_eff;

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = '0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (win_d),
    .any_req_o (any_req_d)
  );

  // Data mux driven by the registered grant, so it only selects the current winner.
  always_comb begin
    wr_dat_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) wr_dat_d = wr_data[i*DW +: DW];
    end
  end

  assign win_idx_d = PW'(onehot_to_idx(MAX_REQ'(gnt_q)));
  assign wr_ok_d   = |(req & gnt_q);
  assign hold_d    = (|(lock_eff & gnt_q)) && (lock_cnt_q < LCW'(LOCK_MAX - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      q_q        <= '0;
      q_vld_q    <= 1'b0;
      ptr_q      <= PW'(N_REQ - 1);
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          q_vld_q    <= 1'b0;
          lock_cnt_q <= '0;
          if (any_req_d) begin
            gnt_q   <= win_d;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (wr_ok_d) begin
            q_q     <= wr_dat_d;
            ptr_q   <= win_idx_d;
            q_vld_q <= 1'b1;
            if (hold_d) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
              lock_cnt_q <= '0;
              gnt_q      <= '0;
              state_q    <= ST_IDLE;
            end
          end else begin
            // Winner withdrew: nothing written, pointer left where it was.
            q_vld_q    <= 1'b0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          q_vld_q    <= 1'b0;
          lock_cnt_q <= '0;
          gnt_q      <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign q_vld = q_vld_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Scoreboard bench for reg_share_arb: a queue-based reference model predicts grants and writes,
// a negedge monitor compares every cycle. Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_reg_share_arb;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int LOCK_CAP = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic [N-1:0]  req;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]  lock;
  logic [N-1:0]  gnt;
  logic [DW-1:0] q;
  logic          q_vld;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  int            gq[$];
  logic [DW-1:0] qq[$];

  int            m_win = -1;
  int            m_ptr = N - 1;
  int            m_cnt = 0;
  logic [DW-1:0] m_q   = '0;

  always #5 clk = ~clk;

  reg_share_arb #(.N_REQ(N), .DW(DW)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .wr_data (wr_data),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_vld   (q_vld),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic lock_of(input int idx);
`ifdef ARB_LOCK_EN
    return lock[idx];
`else
    return (idx < 0);
`endif
  endfunction

  // Reference model: a pending winner either writes (and maybe keeps the grant) or withdraws.
  always @(posedge clk) begin
    int  idx;
    logic found;
    if (clr) begin
      m_win = -1;
      m_ptr = N - 1;
      m_cnt = 0;
      m_q   = '0;
    end else if (m_win < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_win = idx;
        end
      end
      if (found) begin
        m_cnt = 0;
        gq.push_back(m_win);
      end
    end else if (req[m_win]) begin
      m_q   = wr_data[m_win*DW +: DW];
      m_ptr = m_win;
      m_cnt = m_cnt + 1;
      qq.push_back(m_q);
      if (lock_of(m_win) && m_cnt < LOCK_CAP) gq.push_back(m_win);
      else m_win = -1;
    end else begin
      m_win = -1;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]  exp_g;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    exp_g = '0;
    if (gq.size() > 0) exp_g[gq.pop_front()] = 1'b1;
    exp_v = (qq.size() > 0);
    exp_d = exp_v ? qq.pop_front() : m_q;
    check("gnt", 32'(gnt), 32'(exp_g));
    check("busy", 32'(busy), 32'(|exp_g));
    check("q_vld", 32'(q_vld), 32'(exp_v));
    check("q", 32'(q), 32'(exp_d));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] ramp(input logic [DW-1:0] base);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = base + DW'(i);
    return d;
  endfunction

  initial begin
    clr = 1'b1; req = '0; wr_data = '0; lock = '0;
    tick(2);
    clr = 1'b0;
    tick(8);

    // All requesters held: strict rotation 0,1,2,3,0.
    wr_data = ramp(8'hA0);
    req = 4'b1111;
    tick(10);
    req = '0;
    tick(3);

    // Requester 2 pulses and withdraws during its grant.
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(3);
    req = 4'b0101;
    tick(4);
    req = '0;
    tick(2);

    // Reset lands in a grant cycle: the write of 8'h5C is discarded.
    wr_data = ramp(8'h50);
    wr_data[1*DW +: DW] = 8'h5C;
    req = 4'b0010;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    req = 4'b0011;
    tick(4);
    req = '0;
    tick(2);

    // Single requester with data changing every cycle.
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      wr_data[1*DW +: DW] = DW'(8'h11 * (i + 1));
      tick(1);
    end
    req = '0;
    tick(3);

`ifdef ARB_LOCK_EN
    req = 4'b1001; lock = 4'b1000; wr_data = ramp(8'hC0);
    tick(20);
    req = '0; lock = '0;
    tick(3);
`endif

    for (int c = 0; c < 1500; c++) begin
      req     = N'($urandom);
      wr_data = {$urandom};
      lock    = ($urandom_range(0, 3) != 0) ? req : N'($urandom);
      clr     = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    clr = 1'b0; req = '0; lock = '0;
    tick(4);
    @(negedge clk);
    #1;
    check("gq_drained", 32'(gq.size()), 32'd0);
    check("qq_drained", 32'(qq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
